riscv_insn_encoder: RTL

- Streaming RV32I instruction encoder; inverse of the type-classify / field-extract decode path.
- Takes per-field instruction info plus an instruction type (UNDEF/R/I/S/B/U/J, same 3-bit enumeration and opcode masks as the decode package).
- Packs the fields into a 32-bit instruction word.
- Used by debug-injection and self-test stimulus logic to feed the fetch path, behind a valid/ready handshake with a 2-entry output buffer.

---
 rtl/riscv_insn_encoder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_insn_encoder.sv
// riscv_insn_encoder
//   Streaming RV32I instruction encoder: packs per-field instruction info into a
//   32-bit instruction word (inverse of the type-classify / field-extract decode
//   path). Results pass through a 2-entry {insn, err} FIFO behind valid/ready
//   handshakes on both sides.
//
//   Optional build macro: RISCV_ENC_IMM_CHECK_EN
//     defined   - immediate range checks per type; a violation flags err
//     undefined - out-of-field immediate bits are silently dropped
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready from registered occupancy)
//   in_type             0 UNDEF, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J (7 illegal)
//   in_opcode .. in_imm instruction fields; in_imm is sign-extended
//   out_valid/out_ready output handshake
//   out_insn, out_err   encoded word and its error flag (insn=0 on error)
//   out_count           completed output handshakes, wraps at 2^CNT_W
module riscv_insn_encoder #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_type,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [2:0]       in_funct3,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_insn,
   output logic             out_err,
   output logic [CNT_W-1:0] out_count
);

   if (DEPTH != 2) begin : g_depth_check
      $error("riscv_insn_encoder: DEPTH must be 2");
   end

   localparam logic [2:0] TypeR = 3'd1;
   localparam logic [2:0] TypeI = 3'd2;
   localparam logic [2:0] TypeS = 3'd3;
   localparam logic [2:0] TypeB = 3'd4;
   localparam logic [2:0] TypeU = 3'd5;
   localparam logic [2:0] TypeJ = 3'd6;

   localparam logic [6:0] OpcReg    = 7'b0110011;
   localparam logic [6:0] OpcImm    = 7'b0010011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcSystem = 7'b1110011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcJal    = 7'b1101111;

   // ------------------------------------------------------------------
   // Field packing and error detection
   // ------------------------------------------------------------------
   logic [31:0] enc_insn;
   logic        opc_ok;
   logic        imm_ok;
   logic        enc_err;
   logic [32:0] enc_word;   // {insn, err}

   always_comb begin
      enc_insn = '0;
      opc_ok   = 1'b0;
      imm_ok   = 1'b1;
      case (in_type)
         TypeR: begin
            enc_insn = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            opc_ok   = (in_opcode == OpcReg);
         end
         TypeI: begin
            enc_insn = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            opc_ok   = (in_opcode == OpcImm) || (in_opcode == OpcLoad) ||
                       (in_opcode == OpcJalr) || (in_opcode == OpcSystem);
`ifdef RISCV_ENC_IMM_CHECK_EN
            imm_ok   = (&in_imm[31:11]) || (~|in_imm[31:11]);
`endif
         end
         TypeS: begin
            enc_insn = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            opc_ok   = (in_opcode == OpcStore);
`ifdef RISCV_ENC_IMM_CHECK_EN
            imm_ok   = (&in_imm[31:11]) || (~|in_imm[31:11]);
`endif
         end
         TypeB: begin
            enc_insn = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], in_opcode};
            opc_ok   = (in_opcode == OpcBranch);
`ifdef RISCV_ENC_IMM_CHECK_EN
            imm_ok   = ((&in_imm[31:12]) || (~|in_imm[31:12])) && !in_imm[0];
`endif
         end
         TypeU: begin
            enc_insn = {in_imm[31:12], in_rd, in_opcode};
            opc_ok   = (in_opcode == OpcLui) || (in_opcode == OpcAuipc);
`ifdef RISCV_ENC_IMM_CHECK_EN
            imm_ok   = (~|in_imm[11:0]);
`endif
         end
         TypeJ: begin
            enc_insn = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            opc_ok   = (in_opcode == OpcJal);
`ifdef RISCV_ENC_IMM_CHECK_EN
            imm_ok   = ((&in_imm[31:20]) || (~|in_imm[31:20])) && !in_imm[0];
`endif
         end
         default: ;  // UNDEF and 7: opc_ok stays 0
      endcase
   end

   assign enc_err  = !opc_ok || !imm_ok;
   // An all-zero word is architecturally illegal, so errored words carry it.
   assign enc_word = enc_err ? {32'h0, 1'b1} : {enc_insn, 1'b0};

   // ------------------------------------------------------------------
   // 2-entry output FIFO
   // ------------------------------------------------------------------
   logic [32:0]      mem_q [DEPTH];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic [1:0]       count_d;
   logic [32:0]      last_q;     // last word handed out, shown while empty
   logic [32:0]      head;
   logic [CNT_W-1:0] out_count_q;
   logic             push;
   logic             pop;

   assign in_ready  = (count_q < 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign head      = mem_q[rd_ptr_q];
   assign out_insn  = out_valid ? head[32:1] : last_q[32:1];
   assign out_err   = out_valid ? head[0] : last_q[0];
   assign out_count = out_count_q;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         last_q      <= '0;
         out_count_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q    <= ~rd_ptr_q;
            last_q      <= head;
            out_count_q <= out_count_q + CNT_W'(1);
         end
         count_q <= count_d;
      end
   end

endmodule
